hwag_angle_step: RTL
====================

Name: hwag_angle_step

Overview:
- Downstream stage of the hardware angle generator (crank trigger-wheel tracker).
- The tracker supplies a tooth-edge strobe, the current tooth index, the last captured tooth period and a gap-tooth flag.
- This block divides each tooth interval into 2^STEP_SHIFT equal angle steps by timing against the previous tooth period.
- It outputs a running fine angle counter plus a per-step strobe, for use by ignition/injection comparators.

Parameters:
PCNT_WIDTH, 24, width of the tooth period input (clk counts)
TCNT_WIDTH, 8, width of the tooth index input
STEP_SHIFT, 6, log2 of steps per tooth (64)
GAP_MULT, 3, tooth intervals spanned by the gap interval (60-2 wheel)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
start  in  1  tracker synchronised; low forces IDLE
edge  in  1  one-cycle tooth-edge strobe, already filtered
tcnt  in  TCNT_WIDTH  index of the tooth starting at this edge; valid in the edge cycle
period  in  PCNT_WIDTH  last full tooth period; valid in the edge cycle
gap  in  1  the interval starting at this edge is the gap; valid in the edge cycle
acnt  out  TCNT_WIDTH+STEP_SHIFT  fine angle = tcnt*2^STEP_SHIFT + sub-step
tick  out  1  one-cycle strobe on every acnt increment
stall  out  1  step budget for the current interval is exhausted and the block is waiting for an edge
running  out  1  state is RUN or HOLD

Behaviour:
- Reset (rst=0, async): state IDLE; acnt, tick, stall, running, sub, timer, step_per all 0.
- Step period:
  - step_per = period >> STEP_SHIFT, latched in the edge cycle.
  - If the result is 0, step_per = 1.
- Step limit:
  - limit = 2^STEP_SHIFT-1 normally.
  - limit = GAP_MULT*2^STEP_SHIFT-1 when gap=1 in the edge cycle.
  - Latched together with step_per.
- States:
  - IDLE: outputs 0. Moves to RUN on an edge cycle with start=1.
  - RUN: the timer counts clk. When timer==step_per-1 and sub<limit:
    - timer<=0, sub<=sub+1, acnt<=acnt+1, tick=1 (registered, asserts the cycle after the condition).
    - If sub+1==limit after the increment, go to HOLD.
  - HOLD: timer frozen, stall=1, no ticks. Stay until the next edge.
  - Any state with start=0: go to IDLE next cycle and clear all outputs. start has priority over edge.
- Edge handling (start=1, state RUN or HOLD, or IDLE entry):
  - acnt <= {tcnt, STEP_SHIFT'b0}; sub<=0; timer<=0; step_per and limit re-latched; state RUN; stall<=0.
  - Latency: acnt shows the new tooth base 1 clk after the edge cycle.
- Simultaneous edge and step completion in the same cycle: the edge wins; no tick is issued and acnt takes the tooth base.
- Early edge (sub<limit): acnt snaps forward to the tooth base; skipped steps are not ticked.
- acnt is never decremented except by an edge carrying a lower tcnt (wheel wrap).
- Wrap: the tooth index wraps at the tracker; acnt follows tcnt and has no internal modulo.
- Width rules:
  - acnt is exactly TCNT_WIDTH+STEP_SHIFT bits.
  - sub is STEP_SHIFT+2 bits, enough for GAP_MULT<=3.
  - timer is PCNT_WIDTH-STEP_SHIFT bits.
- Reset mid-interval: immediate IDLE. The first edge after reset with start=1 restarts stepping from that edge's tcnt.

Test Plan:
- Reset, then start=1 and edge with tcnt=5, period=6400, gap=0 -> acnt=320 one clk later; tick every 100 clk; acnt reaches 383 after 63 ticks (6300 clk); then stall=1 and no further ticks.
- From that HOLD state, edge with tcnt=6 -> acnt=384, stall=0 the next clk; ticks resume at the 100-clk spacing.
- Edge with gap=1, period=6400, tcnt=57 -> 191 ticks at 100 clk; acnt runs from 3648 to 3839; stall after the 191st tick; next edge with tcnt=0 gives acnt=0.
- Early edge at 4000 clk after a period=6400 edge on tcnt=10 (acnt=679) with tcnt=11 -> acnt=704 next clk; no tick in the edge cycle; remaining steps dropped.
- period=40 -> step_per=1 (clamped from 0); a tick on every clk for 63 cycles, then stall.
- start falls mid-RUN -> next clk acnt=0, running=0, tick=0; edges are ignored until start=1. Async rst=0 mid-RUN -> outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/hwag_angle_step.sv
// Angle step generator: splits each crank tooth interval into 2^STEP_SHIFT
// fine steps timed from the previous tooth period.
module hwag_angle_step #(
  parameter int PCNT_WIDTH = 24,
  parameter int TCNT_WIDTH = 8,
  parameter int STEP_SHIFT = 6,
  parameter int GAP_MULT   = 3
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             start_i,
  input  logic                             edge_i,
  input  logic [TCNT_WIDTH-1:0]            tcnt_i,
  input  logic [PCNT_WIDTH-1:0]            period_i,
  input  logic                             gap_i,
  output logic [TCNT_WIDTH+STEP_SHIFT-1:0] acnt_o,
  output logic                             tick_o,
  output logic                             stall_o,
  output logic                             running_o
);

  localparam int AW = TCNT_WIDTH + STEP_SHIFT;
  localparam int SW = STEP_SHIFT + 2;
  localparam int TW = PCNT_WIDTH - STEP_SHIFT;
  localparam logic [SW-1:0] LIM_NORM = SW'((1 << STEP_SHIFT) - 1);
  localparam logic [SW-1:0] LIM_GAP  = SW'(GAP_MULT * (1 << STEP_SHIFT) - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   acnt_q, acnt_d;
  logic [SW-1:0]   sub_q, sub_d;
  logic [SW-1:0]   limit_q, limit_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [TW-1:0]   step_per_q, step_per_d;
  logic            tick_q, tick_d;
  logic            stall_q, stall_d;
  logic            running_q, running_d;

  logic [TW-1:0]   per_shift_s;
  logic [TW-1:0]   step_per_new_s;

  // A period shorter than one step would give a zero step length; clamp to 1 clk.
  assign per_shift_s    = period_i[PCNT_WIDTH-1:STEP_SHIFT];
  assign step_per_new_s = (per_shift_s == {TW{1'b0}}) ? TW'(1) : per_shift_s;

  // Next-state and output decode; start has priority over edge, edge over stepping.
  always_comb begin
    state_d    = state_q;
    acnt_d     = acnt_q;
    sub_d      = sub_q;
    limit_d    = limit_q;
    timer_d    = timer_q;
    step_per_d = step_per_q;
    tick_d     = 1'b0;
    stall_d    = stall_q;
    running_d  = running_q;

    if (!start_i) begin
      state_d   = IDLE;
      acnt_d    = {AW{1'b0}};
      sub_d     = {SW{1'b0}};
      timer_d   = {TW{1'b0}};
      stall_d   = 1'b0;
      running_d = 1'b0;
    end else if (edge_i) begin
      state_d    = RUN;
      acnt_d     = {tcnt_i, {STEP_SHIFT{1'b0}}};
      sub_d      = {SW{1'b0}};
      timer_d    = {TW{1'b0}};
      step_per_d = step_per_new_s;
      limit_d    = gap_i ? LIM_GAP : LIM_NORM;
      stall_d    = 1'b0;
      running_d  = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if ((timer_q == (step_per_q - TW'(1))) && (sub_q < limit_q)) begin
            timer_d = {TW{1'b0}};
            sub_d   = sub_q + SW'(1);
            acnt_d  = acnt_q + AW'(1);
            tick_d  = 1'b1;
            if ((sub_q + SW'(1)) == limit_q) begin
              state_d = HOLD;
              stall_d = 1'b1;
            end else begin
              state_d = RUN;
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        HOLD: begin
          stall_d = 1'b1;
        end
        IDLE: begin
          running_d = 1'b0;
        end
        default: begin
          state_d   = IDLE;
          acnt_d    = {AW{1'b0}};
          sub_d     = {SW{1'b0}};
          timer_d   = {TW{1'b0}};
          stall_d   = 1'b0;
          running_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      acnt_q     <= {AW{1'b0}};
      sub_q      <= {SW{1'b0}};
      limit_q    <= {SW{1'b0}};
      timer_q    <= {TW{1'b0}};
      step_per_q <= {TW{1'b0}};
      tick_q     <= 1'b0;
      stall_q    <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acnt_q     <= acnt_d;
      sub_q      <= sub_d;
      limit_q    <= limit_d;
      timer_q    <= timer_d;
      step_per_q <= step_per_d;
      tick_q     <= tick_d;
      stall_q    <= stall_d;
      running_q  <= running_d;
    end
  end

  assign acnt_o    = acnt_q;
  assign tick_o    = tick_q;
  assign stall_o   = stall_q;
  assign running_o = running_q;

endmodule
